// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between a CPU and a byte-wide
// synchronous RAM (read data arrives one cycle after the address).
// Two requesters share the RAM: instruction fetch (always 4 bytes) and data
// access (1/2/4 bytes, read or write). Data wins when both ask in IDLE.
// FSM: IDLE -> READ/WRITE -> DONE (one-cycle ack) -> IDLE.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low = freeze)
//   if_req/if_addr -> if_ack/if_inst                   : fetch channel
//   mem_req/we/size/signed/addr/wdata -> mem_ack/rdata : data channel
//   ram_a/ram_dout/ram_wr -> RAM, ram_din <- RAM
//   pc_flag : high in READ/DONE of a fetch
//   io_buffer_full : only used with MEM_CTRL_IO_STALL_EN
//
// Build option: define MEM_CTRL_IO_STALL_EN to hold off data writes to
// address window mem_addr[17:16]==2'b11 while io_buffer_full is high.
module mem_ctrl #(
   parameter int LEN        = 32,
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  if_req,
   input  logic [LEN-1:0]        if_addr,
   output logic                  if_ack,
   output logic [LEN-1:0]        if_inst,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [1:0]            mem_size,
   input  logic                  mem_signed,
   input  logic [LEN-1:0]        mem_addr,
   input  logic [LEN-1:0]        mem_wdata,
   output logic                  mem_ack,
   output logic [LEN-1:0]        mem_rdata,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic [7:0]            ram_dout,
   output logic                  ram_wr,
   input  logic [7:0]            ram_din,
   output logic                  pc_flag,
   input  logic                  io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic           fetch_q, fetch_d;
   logic [LEN-1:0] addr_q, addr_d;
   logic [LEN-1:0] wdata_q, wdata_d;
   logic [1:0]     size_q, size_d;
   logic           signed_q, signed_d;
   logic [LEN-1:0] buf_q, buf_d;
   logic           issued_q, issued_d;
   logic [1:0]     issued_idx_q, issued_idx_d;
   logic [LEN-1:0] if_inst_q, if_inst_d;
   logic [LEN-1:0] mem_rdata_q, mem_rdata_d;

   logic [2:0]     nbytes;
   logic [LEN-1:0] byte_addr;
   logic [LEN-1:0] rd_result;
   logic           issue;
   logic           io_block;

`ifdef MEM_CTRL_IO_STALL_EN
   assign io_block = io_buffer_full && mem_req && mem_we && (mem_addr[17:16] == 2'b11);
`else
   assign io_block = 1'b0;
`endif

   // size 11 is treated as word; fetches latch size 10
   assign nbytes    = (size_q == 2'b00) ? 3'd1 : (size_q == 2'b01) ? 3'd2 : 3'd4;
   assign byte_addr = addr_q + LEN'(cnt_q);
   assign issue     = ((state_q == READ) && (cnt_q < nbytes)) || (state_q == WRITE);

   assign ram_a    = issue ? byte_addr[ADDR_WIDTH-1:0] : '0;
   assign ram_wr   = (state_q == WRITE) && rdy_in;
   assign ram_dout = (state_q == WRITE) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : '0;
   assign if_ack   = (state_q == DONE) && fetch_q;
   assign mem_ack  = (state_q == DONE) && !fetch_q;
   assign pc_flag  = fetch_q && ((state_q == READ) || (state_q == DONE));
   assign if_inst  = if_inst_q;
   assign mem_rdata = mem_rdata_q;

   logic unused_bits;
   assign unused_bits = ^{byte_addr[LEN-1:ADDR_WIDTH], io_buffer_full};

   // Capture tracks which byte was on ram_a last cycle, independent of
   // rdy_in: the RAM keeps answering during a freeze, so the byte that was
   // in flight is taken as it arrives and the re-issued address lines up.
   always_comb begin
      buf_d = buf_q;
      if (issued_q) buf_d[{issued_idx_q, 3'b000} +: 8] = ram_din;
   end

   assign issued_d     = (state_q == READ) && (cnt_q < nbytes);
   assign issued_idx_d = cnt_q[1:0];

   always_comb begin
      case (size_q)
         2'b00:   rd_result = {{(LEN-8){signed_q & buf_d[7]}}, buf_d[7:0]};
         2'b01:   rd_result = {{(LEN-16){signed_q & buf_d[15]}}, buf_d[15:0]};
         default: rd_result = buf_d;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fetch_d     = fetch_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      signed_d    = signed_q;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      if (rdy_in) begin
         case (state_q)
            IDLE: begin
               if (!io_block && mem_req) begin
                  fetch_d  = 1'b0;
                  addr_d   = mem_addr;
                  wdata_d  = mem_wdata;
                  size_d   = mem_size;
                  signed_d = mem_signed;
                  cnt_d    = '0;
                  state_d  = mem_we ? WRITE : READ;
               end else if (!io_block && if_req) begin
                  fetch_d  = 1'b1;
                  addr_d   = if_addr;
                  size_d   = 2'b10;
                  signed_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = READ;
               end
            end
            READ: begin
               // cnt == nbytes: last byte arrives this cycle, nothing issued
               if (cnt_q == nbytes) begin
                  state_d = DONE;
                  if (fetch_q) if_inst_d = buf_d;
                  else         mem_rdata_d = rd_result;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            WRITE: begin
               if (cnt_q == nbytes - 3'd1) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            DONE: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fetch_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         buf_q        <= '0;
         issued_q     <= 1'b0;
         issued_idx_q <= '0;
         if_inst_q    <= '0;
         mem_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fetch_q      <= fetch_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         buf_q        <= buf_d;
         issued_q     <= issued_d;
         issued_idx_q <= issued_idx_d;
         if_inst_q    <= if_inst_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: behavioural byte RAM, directed transactions,
// scoreboard of expected acks (channel, cycle, read data) checked by a
// separate monitor.
module tb_mem_ctrl;
   localparam int LEN = 32;
   localparam int AW  = 17;

   logic            clk_in = 1'b0;
   logic            rst_in = 1'b0;
   logic            rdy_in = 1'b1;
   logic            if_req = 1'b0;
   logic [LEN-1:0]  if_addr = '0;
   logic            if_ack;
   logic [LEN-1:0]  if_inst;
   logic            mem_req = 1'b0;
   logic            mem_we = 1'b0;
   logic [1:0]      mem_size = 2'b00;
   logic            mem_signed = 1'b0;
   logic [LEN-1:0]  mem_addr = '0;
   logic [LEN-1:0]  mem_wdata = '0;
   logic            mem_ack;
   logic [LEN-1:0]  mem_rdata;
   logic [AW-1:0]   ram_a;
   logic [7:0]      ram_dout;
   logic            ram_wr;
   logic [7:0]      ram_din = 8'h00;
   logic            pc_flag;
   logic            io_buffer_full = 1'b0;

   mem_ctrl #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
      .pc_flag(pc_flag), .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // byte RAM with a preload port used only while the DUT is in reset
   bit   [7:0]    ram [0:(1<<AW)-1];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_a = '0;
   logic [7:0]    pl_d = '0;
   always @(posedge clk_in) begin
      ram_din <= ram[ram_a];
      if (pl_en)       ram[pl_a]  <= pl_d;
      else if (ram_wr) ram[ram_a] <= ram_dout;
   end

   typedef struct {
      bit          fetch;
      bit          wr;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic expect_ack(input bit f, input bit w, input logic [31:0] d, input int c);
      exp_q.push_back('{fetch: f, wr: w, data: d, cyc: c});
   endtask

   task automatic wait_ack(input int limit);
      int i = 0;
      while (!(if_ack || mem_ack) && i < limit) begin
         step();
         i++;
      end
      if (!(if_ack || mem_ack)) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout cycle=%0d actual=no_ack required=ack", cyc);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_a  = a;
      pl_d  = d;
      step();
   endtask

   task automatic data_txn(input bit we, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] expd, input int lat);
      mem_req = 1'b1; mem_we = we; mem_size = sz; mem_signed = sg;
      mem_addr = a; mem_wdata = wd;
      expect_ack(1'b0, we, expd, cyc + lat);
      step();
      chk("first_ram_a", 32'(ram_a), {15'b0, a[16:0]});
      chk("first_ram_wr", 32'(ram_wr), 32'(we));
      wait_ack(20);
      mem_req = 1'b0;
      step();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_ack"},    32'(if_ack),   32'h0);
      chk({tag, "_mem_ack"},   32'(mem_ack),  32'h0);
      chk({tag, "_pc_flag"},   32'(pc_flag),  32'h0);
      chk({tag, "_ram_wr"},    32'(ram_wr),   32'h0);
      chk({tag, "_ram_a"},     32'(ram_a),    32'h0);
      chk({tag, "_ram_dout"},  32'(ram_dout), 32'h0);
      chk({tag, "_if_inst"},   if_inst,       32'h0);
      chk({tag, "_mem_rdata"}, mem_rdata,     32'h0);
   endtask

   // monitor: every ack pops one expectation
   always @(negedge clk_in) begin
      if (if_ack || mem_ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack cycle=%0d actual=if%b/mem%b required=none", cyc, if_ack, mem_ack);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ack_if",    32'(if_ack),  32'(mon_e.fetch));
            chk("ack_mem",   32'(mem_ack), 32'(!mon_e.fetch));
            chk("ack_cycle", cyc,          mon_e.cyc);
            if (!mon_e.wr)
               chk("rd_data", mon_e.fetch ? if_inst : mem_rdata, mon_e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      step();
      step();
      preload(17'h00100, 8'h13);
      preload(17'h00101, 8'h05);
      preload(17'h00102, 8'h00);
      preload(17'h00103, 8'h00);
      preload(17'h00020, 8'h80);
      preload(17'h00040, 8'h34);
      preload(17'h00041, 8'h92);
      preload(17'h00042, 8'h56);
      preload(17'h00043, 8'h78);
      pl_en = 1'b0;
      rdy_in = 1'b0;   // reset must win over a frozen block
      step();
      chk_all_zero("reset");
      rdy_in = 1'b1;
      rst_in = 1'b1;
      step();

      // fetch 0x100 -> 0x00000513, ack at N+6
      if_req = 1'b1; if_addr = 32'h100;
      n = cyc;
      expect_ack(1'b1, 1'b0, 32'h00000513, n + 6);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("fetch_ram_a", 32'(ram_a), 32'h100 + 32'(k));
         chk("fetch_pc_flag", 32'(pc_flag), 32'h1);
      end
      wait_ack(10);
      if_req = 1'b0;
      step();
      chk("idle_pc_flag", 32'(pc_flag), 32'h0);
      chk("idle_ram_a", 32'(ram_a), 32'h0);

      // byte / half / word reads
      data_txn(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hFFFFFF80, 3);
      data_txn(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h00000080, 3);
      data_txn(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'hFFFF9234, 4);
      data_txn(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h00009234, 4);
      data_txn(1'b0, 2'b11, 1'b1, 32'h40, 32'h0, 32'h78569234, 6);

      // half write across the top of the address space
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b01; mem_signed = 1'b0;
      mem_addr = 32'h1FFFF; mem_wdata = 32'hAABBCCDD;
      n = cyc;
      expect_ack(1'b0, 1'b1, 32'h0, n + 3);
      step();
      chk("hw_wr0", 32'(ram_wr), 32'h1);
      chk("hw_a0", 32'(ram_a), 32'h1FFFF);
      chk("hw_d0", 32'(ram_dout), 32'hDD);
      step();
      chk("hw_wr1", 32'(ram_wr), 32'h1);
      chk("hw_a1", 32'(ram_a), 32'h00000);
      chk("hw_d1", 32'(ram_dout), 32'hCC);
      wait_ack(10);
      mem_req = 1'b0;
      step();
      chk("post_write_ram_wr", 32'(ram_wr), 32'h0);
      data_txn(1'b0, 2'b01, 1'b0, 32'h1FFFF, 32'h0, 32'h0000CCDD, 4);

      // arbitration: data first, fetch after
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h100;
      if_req = 1'b1; if_addr = 32'h40;
      n = cyc;
      expect_ack(1'b0, 1'b0, 32'h00000513, n + 6);
      expect_ack(1'b1, 1'b0, 32'h78569234, n + 13);
      step();
      chk("arb_pc_flag", 32'(pc_flag), 32'h0);
      chk("arb_ram_a", 32'(ram_a), 32'h100);
      wait_ack(20);
      mem_req = 1'b0;
      step();
      wait_ack(20);
      if_req = 1'b0;
      step();

      // rdy_in low during N+2 of a word read
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h40;
      n = cyc;
      expect_ack(1'b0, 1'b0, 32'h78569234, n + 7);
      step();
      chk("stall_a_n1", 32'(ram_a), 32'h40);
      step();
      rdy_in = 1'b0;
      chk("stall_a_n2", 32'(ram_a), 32'h41);
      step();
      chk("stall_a_n3", 32'(ram_a), 32'h41);
      rdy_in = 1'b1;
      wait_ack(20);
      mem_req = 1'b0;
      step();

      // reset in N+3 of a word read (with rdy_in low too): no ack, outputs 0
      mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h40;
      step();
      step();
      step();
      rst_in = 1'b0; rdy_in = 1'b0; mem_req = 1'b0;
      step();
      chk_all_zero("midrst");
      rst_in = 1'b1; rdy_in = 1'b1;
      for (int k = 0; k < 8; k++) step();

      // byte write into the 0x30000 window with io_buffer_full high
      mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_signed = 1'b0;
      mem_addr = 32'h30000; mem_wdata = 32'h0000005A;
      io_buffer_full = 1'b1;
`ifdef MEM_CTRL_IO_STALL_EN
      for (int k = 0; k < 5; k++) begin
         step();
         chk("io_stall_wr", 32'(ram_wr), 32'h0);
      end
      io_buffer_full = 1'b0;
`endif
      n = cyc;
      expect_ack(1'b0, 1'b1, 32'h0, n + 2);
      step();
      chk("io_wr", 32'(ram_wr), 32'h1);
      chk("io_a", 32'(ram_a), 32'h10000);
      chk("io_d", 32'(ram_dout), 32'h5A);
      wait_ack(10);
      mem_req = 1'b0;
      io_buffer_full = 1'b0;
      step();
      data_txn(1'b0, 2'b00, 1'b1, 32'h30000, 32'h0, 32'h0000005A, 3);

      for (int k = 0; k < 4; k++) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter LEN, default 32: instruction, address and data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 17: RAM byte-address width.
REQ-003 SHALL have ports clk_in (in, 1, the single clock) and rst_in (in, 1, synchronous active-low reset); reset is sampled on the rising edge only.
REQ-004 SHALL have port rdy_in (in, 1): global ready; when low, the block freezes.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, LEN), if_ack (out, 1), if_inst (out, LEN): the instruction fetch channel.
REQ-006 SHALL have ports mem_req (in, 1), mem_we (in, 1), mem_size (in, 2; 00 byte, 01 half, 10 word), mem_signed (in, 1), mem_addr (in, LEN), mem_wdata (in, LEN), mem_ack (out, 1), mem_rdata (out, LEN): the data channel.
REQ-007 SHALL have ports ram_a (out, ADDR_WIDTH), ram_dout (out, 8), ram_wr (out, 1, high means write), ram_din (in, 8): the byte-wide synchronous RAM; read data returns one cycle after the address.
REQ-008 SHALL have ports pc_flag (out, 1; high while a fetch is in progress, selects the instruction path in the address/data muxes) and io_buffer_full (in, 1).

Function
REQ-009 SHALL implement the FSM IDLE, READ, WRITE, DONE, plus a 3-bit byte counter cnt.
REQ-010 In IDLE, a high mem_req SHALL win over a high if_req; the losing request stays pending.
REQ-011 Request N: the accepted request is sampled high in cycle N. It goes to READ (fetch, or data with mem_we=0) or WRITE; the address, size and wdata SHALL be latched at that edge.
REQ-012 Byte count n: fetch = 4; data = 1, 2 or 4 per mem_size; mem_size 11 SHALL be treated as word.
REQ-013 READ address: in cycle N+1+k, for k = 0..n-1, ram_a SHALL equal (addr+k)[ADDR_WIDTH-1:0], so 0x1FFFF wraps to 0x00000.
REQ-014 READ capture: the byte k arriving in cycle N+2+k SHALL be captured into bits [8k+7:8k], little-endian.
REQ-015 READ exit: after byte n-1 is captured, the FSM SHALL go to DONE; the ack SHALL be high only in cycle N+2+n.
REQ-016 WRITE: in cycle N+1+k, ram_wr=1, ram_a=addr+k and ram_dout=wdata[8k+7:8k]; the FSM then goes to DONE, and mem_ack SHALL be high only in cycle N+1+n.
REQ-017 DONE: asserts exactly one of if_ack or mem_ack for one cycle, then returns to IDLE. A new request SHALL be accepted no earlier than the cycle after DONE.
REQ-018 Read results: mem_rdata and if_inst SHALL be valid in the ack cycle and held until the next ack on the same channel. Byte and half results are sign-extended if mem_signed=1, else zero-extended.
REQ-019 pc_flag SHALL be 1 in READ/DONE of a fetch and 0 otherwise, including IDLE.
REQ-020 ram_wr SHALL be 0 outside WRITE, and ram_a SHALL be 0 in IDLE.
REQ-021 A requester SHALL hold its req and inputs until its ack; mid-transaction changes to them SHALL be ignored.
REQ-022 Misaligned addresses SHALL NOT be checked.
REQ-023 While rdy_in=0: state, cnt and outputs SHALL hold, except that ram_wr is forced 0; byte k SHALL be re-issued when rdy_in returns.

Reset
REQ-024 At a rising edge with rst_in=0: state=IDLE, cnt=0, and if_ack, mem_ack, pc_flag, ram_wr, ram_a, ram_dout, if_inst, mem_rdata all 0.
REQ-025 Reset mid-transaction SHALL abort it with no ack; bytes already written stay written.
REQ-026 Reset SHALL take priority over rdy_in.

Configuration
REQ-027 With MEM_CTRL_IO_STALL_EN defined: while io_buffer_full=1, a data write with mem_addr[17:16]=2'b11 SHALL NOT be accepted. The FSM stays in IDLE and serves neither channel until io_buffer_full=0.
REQ-028 Without MEM_CTRL_IO_STALL_EN: io_buffer_full SHALL be ignored, and such writes proceed per REQ-016.

Verification
REQ-029 Fetch: if_req, if_addr=0x100, RAM 0x100..0x103 = 13,05,00,00 -> ram_a 0x100..0x103 in N+1..N+4; pc_flag=1; if_ack only in N+6; if_inst=0x00000513.
REQ-030 Signed byte: mem_req, we=0, size=00, signed=1, addr=0x20, RAM=0x80 -> mem_ack in N+3, mem_rdata=0xFFFFFF80. With signed=0 -> 0x00000080.
REQ-031 Half write: size=01, addr=0x1FFFF, wdata=0xAABBCCDD -> ram_wr=1 with (0x1FFFF,DD) then (0x00000,CC); mem_ack in N+3.
REQ-032 Arbitration: if_req and mem_req (word read) both high in N -> data served first, mem_ack in N+6. Fetch accepted in N+7; if_ack in N+13.
REQ-033 rdy_in low in N+2 of a word read -> no ram_a change that cycle; ack delayed by one cycle; data correct. rst_in=0 in N+3 -> no ack, all outputs 0 next cycle.
REQ-034 MEM_CTRL_IO_STALL_EN: byte write to 0x30000 with io_buffer_full=1 for 5 cycles -> no ram_wr and no ack; the write starts the cycle after full drops. Without the macro -> ram_wr=1 in N+1.
